clint_slave: RTL

//   Core-Local Interruptor responder: the slave end of the CLINT port on the system bus interconnect.

---
 rtl/clint_slave.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/clint_slave.sv
// clint_slave: CLINT bus responder holding msip, mtimecmp and mtime.
// Drives per-hart timer (mti_o) and software (msi_o) interrupt lines.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   req_valid/addr/wdata request (held until req_ready)
//   req_we/size          1 = write; size[1:0] = byte/half/word/dword
//   req_ready/rdata      one-cycle response strobe and read data
//   mtime_o              live mtime for the time CSR
//   mti_o, msi_o         per-hart interrupt lines
// Option: CLINT_MTIME_LATCH_EN adds an mtime high-word shadow for RV32.
module clint_slave #(
  parameter int XLEN           = 32,
  parameter int NUM_HARTS      = 1,
  parameter int MTIME_PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic [15:0]          req_addr,
  input  logic [63:0]          req_wdata,
  input  logic                 req_we,
  input  logic [2:0]           req_size,
  output logic                 req_ready,
  output logic [63:0]          req_rdata,
  output logic [63:0]          mtime_o,
  output logic [NUM_HARTS-1:0] mti_o,
  output logic [NUM_HARTS-1:0] msi_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("clint_slave: XLEN must be 32 or 64");
  end
  if (NUM_HARTS < 1 || NUM_HARTS > 8) begin : g_bad_harts
    $error("clint_slave: NUM_HARTS must be 1..8");
  end
  if (MTIME_PRESCALE < 1) begin : g_bad_ps
    $error("clint_slave: MTIME_PRESCALE must be >= 1");
  end

  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_RESP = 1'b1;
  localparam logic [31:0] PS_MAX = 32'(MTIME_PRESCALE - 1);

  logic [0:0]                  state;
  logic [63:0]                 rdata_q;
  logic [63:0]                 mtime;
  logic [31:0]                 presc;
  logic [NUM_HARTS-1:0][63:0]  mtimecmp;
  logic [NUM_HARTS-1:0]        msip;

  logic unused_size2;
  assign unused_size2 = req_size[2];

  logic [1:0]  sz;
  logic [2:0]  off;
  logic [2:0]  midx;
  logic [2:0]  cidx;
  assign sz   = req_size[1:0];
  assign off  = req_addr[2:0];
  assign midx = req_addr[4:2];
  assign cidx = req_addr[5:3];

  logic [7:0]  lanes;
  logic [7:0]  be;
  logic [63:0] bm;
  logic [63:0] rmask;
  logic [63:0] wd_sh;
  logic        misal;

  always_comb begin
    lanes = 8'h00;
    misal = 1'b0;
    unique case (sz)
      2'd0: begin lanes = 8'h01; misal = 1'b0;       end
      2'd1: begin lanes = 8'h03; misal = off[0];     end
      2'd2: begin lanes = 8'h0f; misal = |off[1:0];  end
      default: begin lanes = 8'hff; misal = |off;    end
    endcase
    be    = lanes << off;
    bm    = '0;
    rmask = '0;
    for (int i = 0; i < 8; i++) begin
      bm[8*i +: 8]    = {8{be[i]}};
      rmask[8*i +: 8] = {8{lanes[i]}};
    end
  end

  assign wd_sh = req_wdata << {off, 3'b000};

  // msip is a 32-bit register, so a dword access there is unmapped.
  logic hit_msip;
  logic hit_cmp;
  logic hit_mtime;
  assign hit_msip  = (req_addr[15:5] == 11'd0)
                  && ({1'b0, midx} < 4'(NUM_HARTS))
                  && (sz != 2'd3);
  assign hit_cmp   = (req_addr[15:6] == 10'h100)
                  && ({1'b0, cidx} < 4'(NUM_HARTS));
  assign hit_mtime = (req_addr[15:3] == 13'h17ff);

  logic accept;
  logic wr_ok;
  logic tick;
  assign accept = (state == S_IDLE) && req_valid;
  assign wr_ok  = accept && req_we && !misal;
  assign tick   = (presc == PS_MAX);

  logic [7:0]       msip_pad;
  logic [7:0][63:0] cmp_pad;

  always_comb begin
    msip_pad = '0;
    cmp_pad  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      msip_pad[h] = msip[h];
      cmp_pad[h]  = mtimecmp[h];
    end
  end

  logic [63:0] mtime_rd;

`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] shadow;

  // A word read of the low half snapshots the high half so an RV32
  // pair of reads sees one coherent 64-bit value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (accept && !req_we && hit_mtime
                 && sz == 2'd2 && off == 3'd0) begin
      shadow <= mtime[63:32];
    end
  end

  assign mtime_rd = (sz != 2'd3 && off[2])
                  ? {shadow, mtime[31:0]} : mtime;
`else
  assign mtime_rd = mtime;
`endif

  logic [63:0] cont;
  logic [63:0] rd_val;

  // msip words pack two per 64-bit slot; bit 0 sits in lane 0 or 4.
  always_comb begin
    cont = '0;
    unique case (1'b1)
      hit_msip:  cont = req_addr[2]
                      ? {31'b0, msip_pad[midx], 32'b0}
                      : {63'b0, msip_pad[midx]};
      hit_cmp:   cont = cmp_pad[cidx];
      hit_mtime: cont = mtime_rd;
      default:   cont = '0;
    endcase
    rd_val = misal ? 64'd0 : ((cont >> {off, 3'b000}) & rmask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            state   <= S_RESP;
            rdata_q <= req_we ? 64'd0 : rd_val;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // An mtime write wins over that cycle's increment; presc runs on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= '0;
    end else begin
      presc <= tick ? 32'd0 : presc + 32'd1;
      if (wr_ok && hit_mtime) begin
        mtime <= (mtime & ~bm) | (wd_sh & bm);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr_ok && hit_cmp && cidx == 3'(h)) begin
          mtimecmp[h] <= (mtimecmp[h] & ~bm) | (wd_sh & bm);
        end
        if (wr_ok && hit_msip && midx == 3'(h)
            && off[1:0] == 2'b00) begin
          msip[h] <= req_wdata[0];
        end
      end
    end
  end

  always_comb begin
    mti_o = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mti_o[h] = (mtime >= mtimecmp[h]);
    end
  end

  assign msi_o     = msip;
  assign mtime_o   = mtime;
  assign req_ready = (state == S_RESP);
  assign req_rdata = rdata_q;

endmodule
